// File: rtl/dmix_mixer.sv
// N-input, M-channel mixer with per-input gain/mute and saturating sum; ack NUM_IN+3 cycles after an idle pop.
// No backpressure: pops for pending or in-flight channels merge, and requests are served lowest channel first.
module dmix_mixer #(
  parameter int NUM_IN      = 2,
  parameter int NUM_IN_LOG2 = 1,
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 24,
  parameter int GAIN_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_IN*NUM_CH-1:0]         ack_i,
  input  logic [NUM_IN*NUM_CH*DATA_W-1:0]  data_i,
  input  logic [NUM_IN*GAIN_W-1:0]         gain_i,
  input  logic [NUM_IN-1:0]                mute_i,
  input  logic [NUM_CH-1:0]                pop_i,
  output logic [DATA_W-1:0]                data_o,
  output logic [NUM_CH-1:0]                ack_o,
  output logic                             busy_o,
  output logic                             clip_o,
  input  logic                             clip_clr_i
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + NUM_IN_LOG2;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MIN_V = -(ACC_W'(1) <<< (DATA_W - 1));

  typedef enum logic [1:0] {IDLE, ACC, SAT, OUT} state_t;

  state_t                   state, state_nx;
  logic [NUM_CH-1:0]        pending;
  logic [CH_W-1:0]          ch;
  logic [CH_W-1:0]          sel_ch;
  logic [NUM_IN_LOG2-1:0]   k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] smp [NUM_IN*NUM_CH];

  logic signed [DATA_W-1:0] rd_smp;
  logic [GAIN_W-1:0]        rd_gain;
  logic                     rd_mute;
  logic signed [PROD_W-1:0] smp_x, gain_x, prod;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        res;
  logic                     clamp;
  logic                     last_k;

  // Sample store: a read in the same cycle as a write sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_IN*NUM_CH; j++) smp[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_IN*NUM_CH; j++)
        if (ack_i[j]) smp[j] <= data_i[j*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_smp  = '0;
    rd_gain = '0;
    rd_mute = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (k == NUM_IN_LOG2'(i)) begin
        rd_gain = gain_i[i*GAIN_W +: GAIN_W];
        rd_mute = mute_i[i];
        for (int c = 0; c < NUM_CH; c++)
          if (ch == CH_W'(c)) rd_smp = smp[i*NUM_CH + c];
      end
    end
  end

  always_comb begin
    smp_x  = PROD_W'(rd_smp);
    gain_x = PROD_W'($signed({1'b0, rd_gain}));
    prod   = rd_mute ? '0 : smp_x * gain_x;
  end

  always_comb begin
    shifted = acc >>> (GAIN_W - 1);
    clamp   = 1'b1;
    if (shifted > MAX_V)      res = MAX_V[DATA_W-1:0];
    else if (shifted < MIN_V) res = MIN_V[DATA_W-1:0];
    else begin
      res   = shifted[DATA_W-1:0];
      clamp = 1'b0;
    end
  end

  always_comb begin
    sel_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (pending[c]) sel_ch = CH_W'(c);
  end

  assign last_k = (k == NUM_IN_LOG2'(NUM_IN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ack_o    = '0;
    case (state)
      IDLE: if (pending != '0) state_nx = ACC;
      ACC:  if (last_k) state_nx = SAT;
      SAT:  state_nx = OUT;
      OUT: begin
        ack_o    = NUM_CH'(1) << ch;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE) || (pending != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ch      <= '0;
      k       <= '0;
      acc     <= '0;
      data_o  <= '0;
      clip_o  <= 1'b0;
    end else begin
      // A pop landing in the ack cycle re-arms the channel for another round.
      pending <= (pending & ~ack_o) | pop_i;
      if (state == IDLE && pending != '0) begin
        ch  <= sel_ch;
        k   <= '0;
        acc <= '0;
      end
      if (state == ACC) begin
        acc <= acc + ACC_W'(prod);
        k   <= k + NUM_IN_LOG2'(1);
      end
      if (state == SAT) data_o <= res;
      if (state == SAT && clamp) clip_o <= 1'b1;
      else if (clip_clr_i)       clip_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmix_mixer.sv
// Directed bench for dmix_mixer: expected acks are queued at pop time and matched by an ack monitor.
module tb_dmix_mixer;

  logic         clk;
  logic         rst_n;
  logic [3:0]   ack_i;
  logic [95:0]  data_i;
  logic [15:0]  gain_i;
  logic [1:0]   mute_i;
  logic [1:0]   pop_i;
  logic [23:0]  data_o;
  logic [1:0]   ack_o;
  logic         busy_o;
  logic         clip_o;
  logic         clip_clr_i;

  logic [7:0]         g [2];
  logic               m [2];
  logic signed [23:0] sh [2][2];

  typedef struct {
    logic [1:0]  ch;
    logic [23:0] dat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  assign gain_i = {g[1], g[0]};
  assign mute_i = {m[1], m[0]};

  dmix_mixer #(
    .NUM_IN(2), .NUM_IN_LOG2(1), .NUM_CH(2), .DATA_W(24), .GAIN_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ack_i      (ack_i),
    .data_i     (data_i),
    .gain_i     (gain_i),
    .mute_i     (mute_i),
    .pop_i      (pop_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .busy_o     (busy_o),
    .clip_o     (clip_o),
    .clip_clr_i (clip_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference mix: floor-shifted, clamped sum of gained, unmuted inputs.
  function automatic logic [23:0] mix(input int c);
    longint acc;
    acc = 0;
    for (int i = 0; i < 2; i++)
      if (!m[i]) acc += longint'(sh[i][c]) * longint'(g[i]);
    acc = acc >>> 7;
    if (acc > 64'sh7FFFFF)       acc = 64'sh7FFFFF;
    else if (acc < -64'sh800000) acc = -64'sh800000;
    return acc[23:0];
  endfunction

  always @(negedge clk) begin
    if (ack_o !== 2'b00) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_ack observed=%b expected=none", ack_o);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ack_ch", 32'(ack_o), 32'(e.ch));
        chk("ack_data", 32'(data_o), 32'(e.dat));
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] chm, input int c, input int at);
    exp_t x;
    x.ch  = chm;
    x.dat = mix(c);
    x.cyc = at;
    q.push_back(x);
  endtask

  task automatic wr(input int i, input int c, input logic [23:0] v);
    data_i[(i*2+c)*24 +: 24] = v;
    ack_i = 4'(1) << (i*2+c);
    sh[i][c] = v;
    tick();
    ack_i = '0;
  endtask

  task automatic drive_pop(input logic [1:0] p);
    pop_i = p;
    tick();
    pop_i = '0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && (q.size() > 0 || busy_o); i++) tick();
    chk("drain", q.size(), 0);
  endtask

  task automatic pop_chk(input logic [1:0] p, input int c);
    n = cyc;
    push(p, c, n + 5);
    drive_pop(p);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pop_i = '0; ack_i = '0; data_i = '0; clip_clr_i = 1'b0;
    g[0] = 0; g[1] = 0; m[0] = 0; m[1] = 0;
    for (int i = 0; i < 2; i++) for (int c = 0; c < 2; c++) sh[i][c] = '0;
    #1;
    chk("rst_data", 32'(data_o), 0);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_clip", 32'(clip_o), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Unity passthrough with busy window t+1..t+5
    g[0] = 128; g[1] = 0;
    wr(0, 0, 24'h123456);
    n = cyc;
    push(2'b01, 0, n + 5);
    chk("busy_before", 32'(busy_o), 0);
    drive_pop(2'b01);
    for (int k = 1; k <= 6; k++) begin
      chk("busy_window", 32'(busy_o), 32'(k <= 5));
      tick();
    end
    wait_done();
    chk("passthru_hold", 32'(data_o), 32'h123456);

    // Positive saturation, then clear
    g[0] = 128; g[1] = 128;
    wr(0, 1, 24'h600000);
    wr(1, 1, 24'h600000);
    pop_chk(2'b10, 1);
    chk("sat_pos", 32'(data_o), 32'h7FFFFF);
    chk("clip_set", 32'(clip_o), 1);
    clip_clr_i = 1'b1; tick(); clip_clr_i = 1'b0;
    chk("clip_clr", 32'(clip_o), 0);

    // Negative saturation with clear asserted in the SAT cycle: set wins
    wr(0, 1, 24'h900000);
    wr(1, 1, 24'h900000);
    n = cyc;
    push(2'b10, 1, n + 5);
    drive_pop(2'b10);
    repeat (3) tick();
    clip_clr_i = 1'b1; tick(); clip_clr_i = 1'b0;
    wait_done();
    chk("sat_neg", 32'(data_o), 32'h800000);
    chk("clip_set_wins", 32'(clip_o), 1);

    // Asynchronous reset mid-ACC drops the request
    wr(0, 0, 24'h000005);
    drive_pop(2'b01);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(data_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_clip", 32'(clip_o), 0);
    chk("arst_ack", 32'(ack_o), 0);
    for (int i = 0; i < 2; i++) for (int c = 0; c < 2; c++) sh[i][c] = '0;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("arst_idle", 32'(busy_o), 0);
    pop_chk(2'b01, 0);
    chk("arst_store_cleared", 32'(data_o), 0);

    // Gain, floor rounding, mute
    g[0] = 64; g[1] = 0;
    wr(0, 0, 24'h000003);
    pop_chk(2'b01, 0);
    chk("half_pos", 32'(data_o), 32'h000001);
    wr(0, 0, 24'hFFFFFD);
    pop_chk(2'b01, 0);
    chk("half_neg_floor", 32'(data_o), 32'hFFFFFE);
    wr(1, 0, 24'h7FFFFF);
    g[1] = 128; m[1] = 1'b1;
    pop_chk(2'b01, 0);
    chk("mute", 32'(data_o), 32'hFFFFFE);

    // Arbitration: both channels, lowest first; an extra pop during compute merges
    m[1] = 1'b0; g[0] = 128; g[1] = 128;
    n = cyc;
    push(2'b01, 0, n + 5);
    push(2'b10, 1, n + 10);
    drive_pop(2'b11);
    tick();
    drive_pop(2'b01);
    wait_done();

    // Pop in the ack cycle re-arms the channel
    n = cyc;
    push(2'b01, 0, n + 5);
    push(2'b01, 0, n + 10);
    drive_pop(2'b01);
    while (cyc < n + 5) tick();
    drive_pop(2'b01);
    wait_done();

    // Write to input 1 in the same cycle ACC reads it: old value used
    wr(0, 0, 24'h000010);
    wr(1, 0, 24'h000020);
    n = cyc;
    push(2'b01, 0, n + 5);
    drive_pop(2'b01);
    repeat (2) tick();
    wr(1, 0, 24'h000100);
    wait_done();
    chk("collide_old", 32'(data_o), 32'h000030);
    pop_chk(2'b01, 0);
    chk("collide_new", 32'(data_o), 32'h000110);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmix_mixer.md
Name: dmix_mixer

Overview:
- Parametrised N-input, M-channel digital mixer core in the clk491520 domain.
- Sits between the per-input SPDIF FIFO outputs and dac_drv.
- Replaces single-stream passthrough with per-input gain, mute and saturating summation.
- Serves DAC pop requests per channel with a one-cycle ack and 24-bit signed data, using the same pop/ack/data contract dac_drv already expects.

Parameters:
NUM_IN, 2, number of stereo (or NUM_CH-wide) input streams
NUM_IN_LOG2, 1, ceil(log2(NUM_IN)), min 1
NUM_CH, 2, channels per stream (0 = left, 1 = right, ...)
DATA_W, 24, signed sample width
GAIN_W, 8, unsigned gain width; unity = 2^(GAIN_W-1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
ack_i  in  NUM_IN*NUM_CH  sample strobe; bit (i*NUM_CH+c) writes input i, channel c
data_i  in  NUM_IN*NUM_CH*DATA_W  sample data; slice (i*NUM_CH+c)*DATA_W +: DATA_W
gain_i  in  NUM_IN*GAIN_W  per-input unsigned gain, slice i*GAIN_W +: GAIN_W
mute_i  in  NUM_IN  per-input mute; 1 forces zero contribution
pop_i  in  NUM_CH  one-cycle request for next mixed sample of channel c
data_o  out  DATA_W  mixed, saturated sample; valid when ack_o != 0, held otherwise
ack_o  out  NUM_CH  one-cycle strobe; bit c marks data_o as channel c
busy_o  out  1  high from a pop's acceptance until its ack cycle inclusive
clip_o  out  1  sticky saturation flag
clip_clr_i  in  1  synchronous clear of clip_o

Behaviour:
- Reset (rst_n low, asynchronous):
  - All sample registers = 0; data_o = 0; ack_o = 0; busy_o = 0; clip_o = 0.
  - Pending mask cleared; FSM = IDLE.
  - Effective immediately, including mid-computation; an in-flight request is dropped and never acked.
- Sample store: NUM_IN*NUM_CH registers.
  - Reg (i,c) loads data_i slice on ack_i bit.
  - Reads see the pre-write value when a write and a read hit the same cycle.
- Pending mask (NUM_CH bits): pending |= pop_i every cycle.
  - Bit c clears in the cycle ack_o[c] fires.
  - A pop for a channel already pending, or currently being computed, merges and yields one ack.
  - A pop arriving in the same cycle as that channel's ack re-sets pending and yields a second ack.
- FSM:
  - IDLE: if pending != 0, select the lowest set index c, clear acc, go to ACC with k = 0. Otherwise stay.
  - ACC: one input per cycle. acc += mute[k] ? 0 : signed(sample[k][c]) * {1'b0, gain[k]}. k = 0..NUM_IN-1, then SAT.
  - SAT: res = acc >>> (GAIN_W-1), arithmetic, floor rounding. Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If clamped, set clip_o. Register res into data_o, go to OUT.
  - OUT: ack_o = one-hot c for exactly one cycle, then IDLE.
- Latency: pop in cycle t, with FSM idle and nothing pending → ack in cycle t+NUM_IN+3. IDLE, ACC×NUM_IN, SAT and OUT each take one cycle after capture.
  - Back-to-back requests cost NUM_IN+3 cycles each.
  - Sustained rate must be checked by the integrator against the DAC pop spacing (≥64 cycles at 491.52 MHz / 48 kHz stereo).
- Widths:
  - Product: DATA_W+GAIN_W+1 signed.
  - Accumulator: ACC_W = DATA_W+GAIN_W+1+NUM_IN_LOG2 signed; cannot overflow.
  - gain and mute are sampled live at each ACC step.
- clip_o: set in a SAT cycle with clamping; cleared by clip_clr_i. If both occur in the same cycle, set wins.
- data_o holds its last value between acks; ack_o is never multi-hot.

Test Plan:
1. Async reset: drop rst_n mid-ACC after pop_i=01 → ack_o stays 0 forever; data_o=0, busy_o=0, clip_o=0 immediately; a fresh pop after release acks normally.
2. Unity passthrough, NUM_IN=2: sample(0,0)=0x123456, gain0=128, gain1=0, pop_i=01 at t → ack_o=01 at t+5, data_o=0x123456, busy_o high t+1..t+5.
3. Saturation: both inputs ch1 = 0x600000 at unity, pop_i=10 → data_o=0x7FFFFF, clip_o=1. Both = 0x900000 → data_o=0x800000. clip_clr_i pulse → clip_o=0.
4. Gain/rounding/mute: sample(0,0)=3, gain 64 → 1. Sample = -3 (0xFFFFFD), gain 64 → 0xFFFFFE. Input 1 set to 0x7FFFFF with mute1=1 → result unchanged.
5. Arbitration: pop_i=11 at t → ack 01 at t+5, ack 10 at t+10. Extra pop_i=01 at t+2 → merged, no third ack. pop_i=01 exactly at t+5 → additional ack 01 follows.
6. Write/read collision: ack_i for (1,0) with 0x000100 in the same cycle ACC reads input 1 → old value is used; a following pop uses 0x000100.
